imem_boot_ctrl: RTL and testbench
=================================

# imem_boot_ctrl

Boot and load controller for the single-cycle core's byte-addressed instruction memory. Accepts a byte stream over a valid/ready handshake and writes it into consecutive memory locations, four bytes per instruction. Holds the core in reset during loading. Once the programmed number of instructions is written, it hands the memory read address over to the core's PC and releases reset.

## Interface
- ADDR_W, 10, byte address width of instruction memory (matches the core's PC width)
- BYTE_W, 8, width of one memory location / stream byte
- LEN_W, ADDR_W-2, width of the instruction-count field

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- len  in  LEN_W  instruction count, sampled on start; 0 means 2^LEN_W
- in_data  in  BYTE_W  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  controller accepts a byte this cycle
- mem_we  out  1  instruction-memory byte write enable
- mem_waddr  out  ADDR_W  write byte address
- mem_wdata  out  BYTE_W  write data
- cpu_pc  in  ADDR_W  core program counter
- imem_addr  out  ADDR_W  instruction-memory read address
- cpu_rst  out  1  reset to the core, active-high
- busy  out  1  load in progress
- done  out  1  program loaded and core running
- err  out  1  checksum failure (0 when the feature is compiled out)

## Operation
- States: IDLE, LOAD, CHK (present only with the macro), RUN, ERR.
- Reset values: state=IDLE, cpu_rst=1, in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0.
- IDLE: on start, latch `len`, clear the byte counter and go to LOAD. The total byte count is 4*len, or 4*2^LEN_W when len=0.
- LOAD:
  - in_ready=1 and busy=1.
  - Each accepted byte (in_valid && in_ready) is written to byte address cnt, then cnt increments.
  - Bytes for instruction k go to addresses 4k, 4k+1, 4k+2, 4k+3 in stream order.
  - After the final byte is accepted, go to CHK if the macro is defined, otherwise to RUN.
- RUN: cpu_rst=0 and done=1. imem_addr follows cpu_pc combinationally, low two bits passed unchanged.
- In every other state, imem_addr = mem_waddr.
- A start pulse in RUN or ERR reasserts cpu_rst and restarts the load as from IDLE. A start pulse in LOAD or CHK is ignored.
- The address counter is ADDR_W bits wide. When len=0 at ADDR_W=10, the final write lands at address 1023, and the counter wraps to 0 without any further write.
- rst during LOAD aborts the load immediately. Bytes already written stay in memory. All outputs return to their reset values on the next edge.

## Timing
- Write latency: a byte accepted at edge N appears as mem_we=1 with its address and data during cycle N+1. mem_we is high for exactly one cycle per byte.
- in_ready drops in the cycle after the last byte is accepted.
- Without the macro, after the last byte is accepted at edge N:
  - state=RUN and done=1 from cycle N+1;
  - the final mem_we is also high in cycle N+1;
  - cpu_rst is registered and goes low from cycle N+2, so the core never fetches before the last write.
- Back-to-back bytes are accepted every cycle; no throughput bubbles.

## Configuration
- IMEM_BOOT_CHECKSUM_EN defined:
  - An 8-bit additive checksum accumulates every byte accepted in LOAD.
  - CHK keeps in_ready=1 and accepts exactly one more byte. That byte is never written to memory.
  - If it equals the two's complement of the sum, go to RUN.
  - Otherwise go to ERR: err=1, cpu_rst=1, done=0, busy=0. ERR is left only via rst or start.
- Undefined: CHK and ERR are not implemented, err is tied to 0, and no trailing byte is expected.

## Structure
- Shared package: state enum, BOOT_BYTES_PER_INSTR=4 constant, checksum width constant.
- One natural sub-module, `imem_boot_cksum`: accumulator plus compare, instantiated only under the macro.

## Test plan
- Load 3 instructions (len=3) from bytes 00..0B with in_valid held high:
  - 12 mem_we pulses with addresses 0..11 and matching data;
  - cpu_rst falls 2 cycles after the 12th handshake;
  - with cpu_pc=8, imem_addr=8.
- Same load with in_valid toggled every other cycle → identical writes, no duplicated or dropped bytes, busy high throughout.
- len=0, ADDR_W=10 → 1024 writes, last at address 1023, then RUN.
- rst asserted after 5 bytes → next cycle state IDLE, cpu_rst=1, in_ready=0; a subsequent start with len=1 writes addresses 0..3.
- Checksum (macro on):
  - bytes 01 02 03 04 followed by F6 → RUN, err=0;
  - trailing byte F5 → ERR with err=1 and cpu_rst held;
  - start then recovers.
- start pulse while in RUN → cpu_rst=1 next cycle, reload begins at address 0.

Source files
------------

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// IMEM_BOOT_CHECKSUM_EN adds the CHK/ERR states for the trailing checksum byte.
package imem_boot_ctrl_pkg;

   localparam int BOOT_BYTES_PER_INSTR = 4;
   localparam int CKSUM_W              = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
`ifdef IMEM_BOOT_CHECKSUM_EN
      CHK  = 3'd2,
      ERR  = 3'd4,
`endif
      RUN  = 3'd3
   } boot_state_e;

endpackage

// File: rtl/imem_boot_cksum.sv
// Additive 8-bit checksum over the loaded bytes. The trailing byte matches when
// it is the two's complement of the sum. Used only with IMEM_BOOT_CHECKSUM_EN.
module imem_boot_cksum
   import imem_boot_ctrl_pkg::*;
#(
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              acc,
   input  logic [BYTE_W-1:0] data,
   output logic              match
);

   logic [CKSUM_W-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst || clr)
         sum_q <= '0;
      else if (acc)
         sum_q <= sum_q + CKSUM_W'(data);
   end

   // sum + x == 0 (mod 2^CKSUM_W) is the same as x == -sum
   assign match = ((sum_q + CKSUM_W'(data)) == '0);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: streams bytes into instruction memory, holds the core
// in reset while loading, then hands imem_addr to cpu_pc. Option: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_ctrl
   import imem_boot_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int BYTE_W = 8,
   parameter int LEN_W  = ADDR_W-2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [BYTE_W-1:0] mem_wdata,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   boot_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [LEN_W-1:0]  len_q;
   logic [ADDR_W-1:0] last_addr;
   logic              accept, wr, last, restart;

   // len=0 gives 0-1, which wraps to the top address: a full-memory load
   assign last_addr = ADDR_W'(len_q) * ADDR_W'(BOOT_BYTES_PER_INSTR) - ADDR_W'(1);

   assign accept  = in_valid && in_ready;
   assign wr      = accept && (state_q == LOAD);
   assign last    = wr && (cnt_q == last_addr);
`ifdef IMEM_BOOT_CHECKSUM_EN
   assign restart = start && (state_q == IDLE || state_q == RUN || state_q == ERR);
   assign busy    = (state_q == LOAD) || (state_q == CHK);
   assign err     = (state_q == ERR);
`else
   assign restart = start && (state_q == IDLE || state_q == RUN);
   assign busy    = (state_q == LOAD);
   assign err     = 1'b0;
`endif
   assign in_ready  = busy;
   assign done      = (state_q == RUN);
   assign imem_addr = (state_q == RUN) ? cpu_pc : mem_waddr;

`ifdef IMEM_BOOT_CHECKSUM_EN
   logic ck_ok;

   imem_boot_cksum #(.BYTE_W(BYTE_W)) u_cksum (
      .clk   (clk),
      .rst   (rst),
      .clr   (restart),
      .acc   (wr),
      .data  (in_data),
      .match (ck_ok)
   );
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            if (last) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = RUN;
`endif
            end
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         CHK:  if (accept) state_d = ck_ok ? RUN : ERR;
         ERR:  if (start) state_d = LOAD;
`endif
         RUN:  if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         cpu_rst   <= 1'b1;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         state_q <= state_d;
         // released one cycle after RUN is entered so the last write lands first
         cpu_rst <= !((state_q == RUN) && !start);
         mem_we  <= wr;
         if (wr) begin
            mem_waddr <= cnt_q;
            mem_wdata <= in_data;
            cnt_q     <= cnt_q + ADDR_W'(1);
         end
         if (restart) begin
            len_q <= len;
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: randomized byte streams against a
// queue model of expected memory writes (checksum scenarios under IMEM_BOOT_CHECKSUM_EN).
module tb_imem_boot_ctrl;

   localparam int ADDR_W = 10;
   localparam int BYTE_W = 8;
   localparam int LEN_W  = ADDR_W-2;
   localparam int BUDGET = 5000;

   logic              clk = 1'b0;
   logic              rst, start, in_valid, in_ready, mem_we, cpu_rst, busy, done, err;
   logic [LEN_W-1:0]  len;
   logic [BYTE_W-1:0] in_data, mem_wdata;
   logic [ADDR_W-1:0] mem_waddr, cpu_pc, imem_addr;

   int n_checks = 0;
   int n_pass   = 0;

   logic [ADDR_W+BYTE_W-1:0] got_q[$];
   logic [ADDR_W+BYTE_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   imem_boot_ctrl #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .cpu_pc(cpu_pc), .imem_addr(imem_addr), .cpu_rst(cpu_rst),
      .busy(busy), .done(done), .err(err)
   );

   // every write pulse the memory sees, one entry per high cycle
   always @(negedge clk) if (mem_we === 1'b1) got_q.push_back({mem_waddr, mem_wdata});

   // One full load: n instructions, vmode 0=valid held, 1=toggled, 2=random (with
   // ignored start pulses); base<0 gives random bytes, else bytes base, base+1, ...
   task automatic run_load(input int n, input int vmode, input int base, input bit ck_good);
      int         total, i, cyc, bad;
      logic [7:0] b, sum, tail;
      bit         acc;
      total = (n == 0) ? (1 << ADDR_W) : 4*n;
      got_q.delete(); exp_q.delete();
      start = 1'b1; len = LEN_W'(n); @(posedge clk); #1; start = 1'b0;
      n_checks++;
      if ({busy, cpu_rst, done, in_ready} !== 4'b1101)
         $display("FAIL start_entry: busy/cpu_rst/done/in_ready=%b want 1101", {busy, cpu_rst, done, in_ready});
      else n_pass++;
      i = 0; cyc = 0; sum = 8'h00;
      while (i < total && cyc < BUDGET) begin
         case (vmode)
            0: in_valid = 1'b1;
            1: in_valid = (cyc[0] == 1'b0);
            default: in_valid = ($urandom_range(99) < 70);
         endcase
         b = (base < 0) ? 8'($urandom) : 8'(base + i);
         in_data = b;
         if (vmode == 2 && $urandom_range(15) == 0) begin
            start = 1'b1; len = LEN_W'($urandom);
         end
         acc = in_valid && in_ready;
         n_checks++;
         if (busy !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL busy_in_load: busy=%b in_ready=%b byte %0d want 1 1", busy, in_ready, i);
         else n_pass++;
         @(posedge clk); #1; start = 1'b0; cyc++;
         if (acc) begin
            exp_q.push_back({i[ADDR_W-1:0], b});
            sum = sum + b; i++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (cyc >= BUDGET) $display("FAIL load_budget: accepted %0d of %0d bytes", i, total);
      else n_pass++;
      tail = ck_good ? (8'h00 - sum) : (8'h00 - sum - 8'h01);
`ifdef IMEM_BOOT_CHECKSUM_EN
      in_valid = 1'b1; in_data = tail; @(posedge clk); #1; in_valid = 1'b0;
      n_checks++;
      if (ck_good && {done, err, cpu_rst, in_ready} !== 4'b1010)
         $display("FAIL ck_good: done/err/cpu_rst/in_ready=%b want 1010", {done, err, cpu_rst, in_ready});
      else if (!ck_good && {done, err, cpu_rst, busy} !== 4'b0110)
         $display("FAIL ck_bad: done/err/cpu_rst/busy=%b want 0110", {done, err, cpu_rst, busy});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (cpu_rst !== !ck_good) $display("FAIL ck_cpu_rst: got %b want %b", cpu_rst, !ck_good);
      else n_pass++;
`else
      n_checks++;
      if ({done, in_ready, mem_we, cpu_rst, err} !== 5'b10110 || tail === 8'hxx)
         $display("FAIL last_cycle: done/in_ready/mem_we/cpu_rst/err=%b want 10110",
                  {done, in_ready, mem_we, cpu_rst, err});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (cpu_rst !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL release: cpu_rst=%b mem_we=%b want 0 0", cpu_rst, mem_we);
      else n_pass++;
`endif
      bad = 0;
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
         if (got_q[k] !== exp_q[k]) bad++;
      n_checks++;
      if (got_q.size() != exp_q.size())
         $display("FAIL write_count: got %0d want %0d", got_q.size(), exp_q.size());
      else n_pass++;
      n_checks++;
      if (bad != 0) $display("FAIL write_data: %0d wrong writes want 0", bad);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; cpu_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({cpu_rst, in_ready, mem_we, busy, done, err} !== 6'b100000)
         $display("FAIL reset_ctrl: cpu_rst/in_ready/mem_we/busy/done/err=%b want 100000",
                  {cpu_rst, in_ready, mem_we, busy, done, err});
      else n_pass++;
      n_checks++;
      if (mem_waddr !== '0 || mem_wdata !== '0 || imem_addr !== '0)
         $display("FAIL reset_data: waddr=%h wdata=%h imem_addr=%h want 0", mem_waddr, mem_wdata, imem_addr);
      else n_pass++;
      rst = 1'b0; @(posedge clk); #1;
      n_checks++;
      if (cpu_rst !== 1'b1 || done !== 1'b0) $display("FAIL idle_hold: cpu_rst=%b done=%b want 1 0", cpu_rst, done);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [ADDR_W-1:0] pc;
      run_load(3, 0, 0, 1'b1);
      cpu_pc = 10'd8; #1;
      n_checks++;
      if (imem_addr !== 10'd8) $display("FAIL pc_handover: got %h want 008", imem_addr);
      else n_pass++;
      pc = ADDR_W'($urandom) | 10'h003; cpu_pc = pc; #1;
      n_checks++;
      if (imem_addr !== pc) $display("FAIL pc_follow: got %h want %h", imem_addr, pc);
      else n_pass++;
      cpu_pc = '0;
   endtask

   task automatic test_toggle();
      run_load(3, 1, 0, 1'b1);
      run_load(4, 2, -1, 1'b1);
   endtask

   task automatic test_len0();
      run_load(0, 2, -1, 1'b1);
      n_checks++;
      if (got_q.size() == 0 || got_q[got_q.size()-1][ADDR_W+BYTE_W-1:BYTE_W] !== 10'd1023)
         $display("FAIL len0_last: final write address wrong, %0d writes, want last at 1023", got_q.size());
      else n_pass++;
      n_checks++;
      if (done !== 1'b1) $display("FAIL len0_run: done=%b want 1", done);
      else n_pass++;
   endtask

   task automatic test_abort();
      got_q.delete();
      start = 1'b1; len = LEN_W'(2); @(posedge clk); #1; start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = 8'hA0 + 8'(k); @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1; @(posedge clk); #1;
      n_checks++;
      if ({cpu_rst, in_ready, busy, done, mem_we} !== 5'b10000 || mem_waddr !== '0)
         $display("FAIL abort_state: cpu_rst/in_ready/busy/done/mem_we=%b waddr=%h want 10000 0",
                  {cpu_rst, in_ready, busy, done, mem_we}, mem_waddr);
      else n_pass++;
      n_checks++;
      if (got_q.size() != 5 || got_q[got_q.size()-1] !== {10'd4, 8'hA4})
         $display("FAIL abort_writes: %0d writes want 5 ending 4:a4", got_q.size());
      else n_pass++;
      rst = 1'b0; @(posedge clk); #1;
      run_load(1, 0, -1, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_load(2, 2, -1, 1'b1);
      run_load(1, 1, -1, 1'b1);
   endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
   task automatic test_checksum();
      run_load(1, 0, 1, 1'b1);
      run_load(1, 0, 1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({err, cpu_rst, done} !== 3'b110) $display("FAIL err_hold: err/cpu_rst/done=%b want 110", {err, cpu_rst, done});
      else n_pass++;
      run_load(2, 2, -1, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_len0();
      test_abort();
      test_back_to_back();
`ifdef IMEM_BOOT_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
